// File: rtl/my_csr_unit_pkg.sv
// Shared CSR addresses, mstatus layout, operation encoding and write-value helper for my_csr_unit.
// Optional 64-bit counters are enabled with MY_CSR_PERF_COUNTERS_EN (see my_csr_unit.sv).
package my_csr_unit_pkg;

  localparam int unsigned IRQ_ID_W = 5;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic [1:0] mpp;
    logic       mpie;
    logic       mie;
  } mstatus_t;

  function automatic logic [31:0] mstatus_word(input mstatus_t s);
    return {19'b0, s.mpp, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
  endfunction

  function automatic logic [31:0] csr_wval(input csr_op_e op, input logic [31:0] old_v,
                                           input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: return wdata;
      CSR_OP_RS: return old_v | wdata;
      CSR_OP_RC: return old_v & ~wdata;
      default:   return old_v;
    endcase
  endfunction

endpackage

// File: rtl/my_csr_unit_irq_arbiter.sv
// my_irq_arbiter: fixed-priority interrupt arbiter, highest pending line index wins.
// Purely combinational: pend vector -> {any, id}.
module my_irq_arbiter
  import my_csr_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 3
) (
  input  logic [NUM_IRQ-1:0]  pend_i,
  output logic                any_o,
  output logic [IRQ_ID_W-1:0] id_o
);

  always_comb begin
    any_o = |pend_i;
    id_o  = '0;
    // Ascending scan so the last (highest) set index overwrites lower ones.
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (pend_i[i]) id_o = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/my_csr_unit.sv
// Machine-mode CSR file and trap controller: mstatus/mie/mip/mtvec/mepc/mcause/mtval/mscratch/mhartid/misa.
// Define MY_CSR_PERF_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module my_csr_unit
  import my_csr_unit_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 3,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_1100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [1:0]          c_csr_op_i,
  input  logic                c_readcsr_i,
  input  logic                c_writecsr_i,
  input  logic [31:0]         csr_wdata_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_illegal_o,
  input  logic                c_mret_i,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                irq_req_o,
  output logic [4:0]          irq_id_o,
  input  logic                irq_taken_i,
  input  logic                exc_taken_i,
  input  logic [4:0]          exc_id_i,
  input  logic [31:0]         exc_tval_i,
  input  logic [31:0]         exc_pc_i,
  input  logic                instr_ret_i,
  output logic                mstatus_mie_o,
  output logic [31:0]         mtvec_o,
  output logic [31:0]         mepc_o,
  output logic [5:0]          mcause_o,
  output logic [31:0]         trap_pc_o
);

  mstatus_t           mstatus_q, mstatus_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d, mip_q, mip_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        mscratch_q, mscratch_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mtval_q, mtval_d;
  logic               mcause_intr_q, mcause_intr_d;
  logic [4:0]         mcause_code_q, mcause_code_d;

  logic [63:0]        mcycle_val, minstret_val;
  logic [31:0]        csr_old, csr_new;
  logic               csr_legal, csr_we, irq_take;
  logic               irq_any;
  logic [4:0]         irq_id;
  logic [NUM_IRQ-1:0] irq_pend;
  logic [31:0]        trap_base;

  // Interrupt handshake: irq_req_o is a level derived only from registers; the core accepts
  // it by raising irq_taken_i for one cycle while irq_req_o=1. irq_taken_i with irq_req_o=0 is ignored.
  assign irq_pend  = mip_q & mie_q;
  assign irq_req_o = mstatus_q.mie & irq_any;
  assign irq_id_o  = irq_id;
  assign irq_take  = irq_taken_i & irq_req_o;

  my_irq_arbiter #(.NUM_IRQ(NUM_IRQ)) u_irq_arbiter (
    .pend_i (irq_pend),
    .any_o  (irq_any),
    .id_o   (irq_id)
  );

  always_comb begin
    csr_legal = 1'b1;
    csr_old   = '0;
    case (csr_addr_i)
      CSR_MSTATUS:   csr_old = mstatus_word(mstatus_q);
      CSR_MISA:      csr_old = MISA_VALUE;
      CSR_MIE:       csr_old = 32'(mie_q);
      CSR_MTVEC:     csr_old = mtvec_q;
      CSR_MSCRATCH:  csr_old = mscratch_q;
      CSR_MEPC:      csr_old = mepc_q;
      CSR_MCAUSE:    csr_old = {mcause_intr_q, 26'b0, mcause_code_q};
      CSR_MTVAL:     csr_old = mtval_q;
      CSR_MIP:       csr_old = 32'(mip_q);
      CSR_MHARTID:   csr_old = HART_ID;
      CSR_MCYCLE:    csr_old = mcycle_val[31:0];
      CSR_MCYCLEH:   csr_old = mcycle_val[63:32];
      CSR_MINSTRET:  csr_old = minstret_val[31:0];
      CSR_MINSTRETH: csr_old = minstret_val[63:32];
      default:       csr_legal = 1'b0;
    endcase
  end

  assign csr_new       = csr_wval(csr_op_e'(c_csr_op_i), csr_old, csr_wdata_i);
  assign csr_rdata_o   = (c_readcsr_i && csr_legal) ? csr_old : 32'b0;
  assign csr_illegal_o = (c_readcsr_i | c_writecsr_i) & ~csr_legal;
  // A CSR write loses to any trap or mret retiring in the same cycle.
  assign csr_we = c_writecsr_i & (c_csr_op_i != CSR_OP_NONE) & csr_legal
                & ~exc_taken_i & ~irq_take & ~c_mret_i;

  always_comb begin
    mstatus_d     = mstatus_q;
    mie_d         = mie_q;
    mip_d         = irq_i;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mtval_d       = mtval_q;
    mcause_intr_d = mcause_intr_q;
    mcause_code_d = mcause_code_q;
    if (exc_taken_i) begin
      mepc_d         = exc_pc_i;
      mcause_intr_d  = 1'b0;
      mcause_code_d  = exc_id_i;
      mtval_d        = exc_tval_i;
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
      mstatus_d.mpp  = PRIV_M;
    end else if (irq_take) begin
      mepc_d         = exc_pc_i;
      mcause_intr_d  = 1'b1;
      mcause_code_d  = irq_id;
      mtval_d        = '0;
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
      mstatus_d.mpp  = PRIV_M;
    end else if (c_mret_i) begin
      mstatus_d.mie  = mstatus_q.mpie;
      mstatus_d.mpie = 1'b1;
      mstatus_d.mpp  = PRIV_M;
    end else if (csr_we) begin
      case (csr_addr_i)
        CSR_MSTATUS: begin
          mstatus_d.mie  = csr_new[MSTATUS_MIE_BIT];
          mstatus_d.mpie = csr_new[MSTATUS_MPIE_BIT];
          mstatus_d.mpp  = PRIV_M;
        end
        CSR_MIE:      mie_d = csr_new[NUM_IRQ-1:0];
        CSR_MTVEC: begin
          mtvec_d[31:2] = csr_new[31:2];
          // Reserved modes 10/11 leave the current mode in place.
          if (csr_new[1:0] == MTVEC_MODE_DIRECT || csr_new[1:0] == MTVEC_MODE_VECTORED)
            mtvec_d[1:0] = csr_new[1:0];
        end
        CSR_MSCRATCH: mscratch_d = csr_new;
        CSR_MEPC:     mepc_d = {csr_new[31:2], 2'b00};
        CSR_MCAUSE: begin
          mcause_intr_d = csr_new[31];
          mcause_code_d = csr_new[4:0];
        end
        CSR_MTVAL:    mtval_d = csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_q     <= '{mpp: PRIV_M, mpie: 1'b0, mie: 1'b0};
      mie_q         <= '0;
      mip_q         <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mtval_q       <= '0;
      mcause_intr_q <= 1'b0;
      mcause_code_q <= '0;
    end else begin
      mstatus_q     <= mstatus_d;
      mie_q         <= mie_d;
      mip_q         <= mip_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mtval_q       <= mtval_d;
      mcause_intr_q <= mcause_intr_d;
      mcause_code_q <= mcause_code_d;
    end
  end

`ifdef MY_CSR_PERF_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  // A write to either half replaces it and holds the counter for that cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_ret_i};
    if (csr_we) begin
      case (csr_addr_i)
        CSR_MCYCLE:    mcycle_d   = {mcycle_q[63:32], csr_new};
        CSR_MCYCLEH:   mcycle_d   = {csr_new, mcycle_q[31:0]};
        CSR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
        CSR_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign mcycle_val   = mcycle_q;
  assign minstret_val = minstret_q;
`else
  logic unused_instr_ret;
  assign unused_instr_ret = instr_ret_i;
  assign mcycle_val       = '0;
  assign minstret_val     = '0;
`endif

  // Trap target follows the recorded cause; only interrupts use the vectored offset.
  assign trap_base = {mtvec_q[31:2], 2'b00};
  assign trap_pc_o = (mtvec_q[1:0] == MTVEC_MODE_VECTORED && mcause_intr_q)
                   ? trap_base + {25'b0, mcause_code_q, 2'b00}
                   : trap_base;

  assign mstatus_mie_o = mstatus_q.mie;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mcause_o      = {mcause_intr_q, mcause_code_q};

endmodule
